// File: rtl/blink_ctrl.sv
// blink_ctrl: drives a single LED through a burst of N on/off blinks.
// A prescaler divides the clock into ticks; a tick counter measures each
// phase in ticks; a remaining-blink counter ends the burst.
// Optional feature macro: BLINK_CTRL_ABORT_EN adds an `abort` input that
// cancels a running burst without a `done` pulse.
module blink_ctrl #(
  parameter int unsigned DIV       = 25000,
  parameter int unsigned ON_TICKS  = 250,
  parameter int unsigned OFF_TICKS = 250,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_blinks,
`ifdef BLINK_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PreW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TickMax = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;

  localparam logic [PreW-1:0]  PreLast = PreW'(DIV - 1);
  localparam logic [TickW-1:0] OnLast  = TickW'(ON_TICKS - 1);
  localparam logic [TickW-1:0] OffLast = TickW'(OFF_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e             state_q, state_d;
  logic [PreW-1:0]    presc_q, presc_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic               done_q, done_d;
  logic               abort_req;
  logic               presc_wrap;

`ifdef BLINK_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign presc_wrap = (presc_q == PreLast);

  // Next-state logic: phase sequencing, counters and done pulse.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    remain_d = remain_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort is ignored here, so start always wins in IDLE
        if (start) begin
          if (n_blinks != '0) begin
            state_d  = StOn;
            remain_d = n_blinks;
            presc_d  = '0;
            tick_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StOn: begin
        if (abort_req) begin
          state_d  = StIdle;
          presc_d  = '0;
          tick_d   = '0;
          remain_d = '0;
        end else if (presc_wrap) begin
          presc_d = '0;
          if (tick_q == OnLast) begin
            state_d = StOff;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      StOff: begin
        if (abort_req) begin
          state_d  = StIdle;
          presc_d  = '0;
          tick_d   = '0;
          remain_d = '0;
        end else if (presc_wrap) begin
          presc_d = '0;
          if (tick_q == OffLast) begin
            tick_d   = '0;
            remain_d = remain_q - 1'b1;
            if (remain_q == CNT_W'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StOn;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: begin
        state_d  = StIdle;
        presc_d  = '0;
        tick_d   = '0;
        remain_d = '0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      tick_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  // Outputs decode straight from flops, so they are glitch-free.
  assign led  = (state_q == StOn);
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_blink_ctrl.sv
// Testbench for blink_ctrl (DIV=2, ON_TICKS=3, OFF_TICKS=2): table vectors,
// directed burst sequences, then random stimulus against a timeline model.
module tb_blink_ctrl;
  localparam int unsigned DIV   = 2;
  localparam int unsigned ON_T  = 3;
  localparam int unsigned OFF_T = 2;
  localparam int unsigned CW    = 4;
  localparam int          ON_CYC = ON_T * DIV;
  localparam int          PER    = (ON_T + OFF_T) * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] n_blinks = '0;
  logic          abort = 1'b0;
  logic          led, busy, done;

  int checks = 0;
  int failures = 0;

  // Reference model: a burst is a timeline position t within N periods.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;
  int m_n      = 0;

  always #5 clk = ~clk;

  blink_ctrl #(
    .DIV      (DIV),
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T),
    .CNT_W    (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n_blinks(n_blinks),
`ifdef BLINK_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    bit          rst;
    bit          start;
    logic [3:0]  n;
    bit          e_led;
    bit          e_busy;
    bit          e_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit abort_eff;
`ifdef BLINK_CTRL_ABORT_EN
    abort_eff = abort;
`else
    abort_eff = 1'b0;
`endif
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_t      = 0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (abort_eff) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t == m_n * PER) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        if (n_blinks == 0) begin
          m_done = 1'b1;
        end else begin
          m_active = 1'b1;
          m_t      = 0;
          m_n      = int'(n_blinks);
        end
      end
    end
  endtask

  // One clock: model follows the edge, then outputs settle by the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    int e_led;
    e_led = (m_active && ((m_t % PER) < ON_CYC)) ? 1 : 0;
    chk({tag, ".led"},  int'(led),  e_led);
    chk({tag, ".busy"}, int'(busy), int'(m_active));
    chk({tag, ".done"}, int'(done), int'(m_done));
  endtask

  task automatic check_out(input string tag, input int e_led, input int e_busy, input int e_done);
    chk({tag, ".led"},  int'(led),  e_led);
    chk({tag, ".busy"}, int'(busy), e_busy);
    chk({tag, ".done"}, int'(done), e_done);
  endtask

  // Run up to `budget` cycles with start low, counting busy cycles and done pulses.
  task automatic count_burst(input int budget, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy) busy_n++;
      if (done) done_n++;
    end
  endtask

  initial begin
    vec_t vecs[$];
    int bn, dn;

    // rst, start, n, led, busy, done (expected after the edge)
    vecs.push_back('{1, 0, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 4'd0, 0, 0, 0});
    vecs.push_back('{0, 0, 4'd0, 0, 0, 0});
    vecs.push_back('{0, 1, 4'd0, 0, 0, 1});  // zero count: done only
    vecs.push_back('{0, 0, 4'd3, 0, 0, 0});
    vecs.push_back('{1, 1, 4'd3, 0, 0, 0});  // start with rst is lost
    vecs.push_back('{0, 0, 4'd3, 0, 0, 0});
    vecs.push_back('{0, 1, 4'd0, 0, 0, 1});
    vecs.push_back('{0, 1, 4'd0, 0, 0, 1});
    vecs.push_back('{0, 0, 4'd0, 0, 0, 0});
    vecs.push_back('{0, 1, 4'd1, 1, 1, 0});
    vecs.push_back('{0, 0, 4'd0, 1, 1, 0});
    vecs.push_back('{1, 0, 4'd0, 0, 0, 0});  // mid-burst reset, no done
    vecs.push_back('{0, 0, 4'd0, 0, 0, 0});

    @(negedge clk);
    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      start    = vecs[i].start;
      n_blinks = vecs[i].n;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_led, vecs[i].e_busy, vecs[i].e_done);
    end

    // Idle stays quiet for 20 cycles.
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_out("idle", 0, 0, 0);
    end

    // Two-blink burst: led 6 high, 4 low, twice; done in cycle 21.
    start = 1'b1; n_blinks = 4'd2;
    for (int i = 0; i < 20; i++) begin
      step();
      start = 1'b0;
      check_out($sformatf("burst2_c%0d", i + 1), ((i % 10) < 6) ? 1 : 0, 1, 0);
    end
    step();
    check_out("burst2_end", 0, 0, 1);
    step();
    check_out("burst2_after", 0, 0, 0);

    // Start re-pulsed while busy is ignored.
    start = 1'b1; n_blinks = 4'd2;
    step();
    start = 1'b0;
    bn = 1; dn = 0;
    for (int i = 0; i < 29; i++) begin
      start = (i >= 3 && i < 8);
      n_blinks = (i >= 3) ? 4'd5 : 4'd2;
      step();
      if (busy) bn++;
      if (done) dn++;
    end
    start = 1'b0;
    chk("ignore_busy_cycles", bn, 20);
    chk("ignore_done_count", dn, 1);

    // Reset in the 9th cycle of a burst.
    start = 1'b1; n_blinks = 4'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_out("pre_rst", 0, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("mid_rst", 0, 0, 0);
    count_burst(5, bn, dn);
    chk("mid_rst_no_done", dn, 0);
    start = 1'b1; n_blinks = 4'd2;
    step();
    start = 1'b0;
    count_burst(25, bn, dn);
    chk("post_rst_busy", bn + 1, 20);
    chk("post_rst_done", dn, 1);

`ifdef BLINK_CTRL_ABORT_EN
    // Abort in the 3rd on-cycle, then restart right away.
    start = 1'b1; n_blinks = 4'd3;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_out("abort", 0, 0, 0);
    start = 1'b1; n_blinks = 4'd1;
    step();
    start = 1'b0;
    check_out("abort_restart", 1, 1, 0);
    count_burst(12, bn, dn);
    chk("abort_restart_done", dn, 1);
    // abort together with start in IDLE: start wins
    start = 1'b1; abort = 1'b1; n_blinks = 4'd1;
    step();
    start = 1'b0; abort = 1'b0;
    check_out("abort_vs_start", 1, 1, 0);
    count_burst(12, bn, dn);
`endif

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 7) == 0);
      n_blinks = CW'($urandom_range(0, 3));
`ifdef BLINK_CTRL_ABORT_EN
      abort    = ($urandom_range(0, 39) == 0);
`endif
      step();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
